seq_detect_prog: RTL
====================

Name: seq_detect_prog

Overview:
Parametrised, run-time programmable serial bit-pattern detector. Successor to the fixed 1011 detector FSM.
Adds pattern and length programmability, overlap/non-overlap mode, an input qualifier, and a saturating match counter.
Sits on a serial bit stream behind a sampler; seq_seen feeds interrupt/event logic and match_count is readable by software.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32); width of pattern/history.
LEN_W, 4, width of pat_len port; must hold MAX_LEN.
DEFAULT_PATTERN, 8'b0000_1011, pattern after reset (right-aligned, MAX_LEN bits).
DEFAULT_LEN, 4, pattern length after reset.
CNT_W, 8, width of match_count.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (low = reset asserted)
inp_bit  input  1  serial data bit
inp_valid  input  1  inp_bit sampled only when high
overlap_en  input  1  1 = overlapping matches allowed; 0 = non-overlapping
cfg_load  input  1  load pattern/pat_len and flush history
pattern  input  MAX_LEN  new pattern, right-aligned; bit [len-1] is first bit received, bit [0] is last
pat_len  input  LEN_W  new pattern length
clr_count  input  1  synchronous clear of match_count and count_sat
seq_seen  output  1  one-cycle match pulse, registered
match_count  output  CNT_W  number of matches, saturating
count_sat  output  1  sticky flag: match_count has saturated

Behaviour:
- Reset (reset low, async):
  - pattern register = DEFAULT_PATTERN, length register = DEFAULT_LEN.
  - history = 0, fill = 0.
  - seq_seen = 0, match_count = 0, count_sat = 0.
- Length clamp: pat_len of 0 or > MAX_LEN loads as MAX_LEN; 1..MAX_LEN loads as given.
- Accept (inp_valid=1, cfg_load=0, rising edge):
  - history <= {history[MAX_LEN-2:0], inp_bit}.
  - fill <= min(fill+1, MAX_LEN).
- Match condition, computed on the post-shift values:
  - lower len bits of the new history equal the lower len bits of the pattern register, AND
  - new fill >= len.
- seq_seen timing:
  - Registered; high exactly in the cycle after the edge that accepted the completing bit; low otherwise.
  - Never high in consecutive cycles unless consecutive valid bits each complete a match (e.g. pattern 11, overlap on, input 111).
- Overlap modes:
  - overlap_en=1: history and fill continue normally after a match.
  - overlap_en=0: on a match, fill <= 0, so the next match needs len fresh bits. history may keep shifting; fill gates matching.
- inp_valid=0: history, fill and seq_seen pulse generation are frozen (seq_seen <= 0). Gaps never break a partial match.
- cfg_load=1 (edge):
  - Load pattern/length registers, history <= 0, fill <= 0, seq_seen <= 0.
  - Any inp_bit on that cycle is discarded. cfg_load takes priority over inp_valid.
- Counter:
  - On each match, match_count increments.
  - At all-ones it holds, and count_sat <= 1 (set on the match attempted while already at max).
  - clr_count=1: match_count <= 0, count_sat <= 0. Clear wins over a simultaneous increment, but seq_seen still pulses for that match.
- overlap_en may change at any time; it is sampled at the edge when a match occurs.
- Reset mid-stream: all state returns to reset values immediately. The first match after release needs len fresh valid bits.
- No combinational path from inputs to outputs.

Test Plan:
1. After reset, overlap_en=1, valid bits 1,0,1,1,0,1,1 on consecutive cycles -> seq_seen pulses in the cycle after bits 4 and 7; match_count=2.
2. Same stream with overlap_en=0 -> single pulse after bit 4; match_count=1.
3. Same stream as test 1 with inp_valid=0 gaps of 1–3 cycles inserted between bits -> pulses in the cycle after the accepting edges of bits 4 and 7; match_count=2; seq_seen=0 during gaps.
4. cfg_load with pattern=3'b110, pat_len=3, then stream 1,1,0,1,1,0 -> pulses after bits 3 and 6. cfg_load=1 with inp_valid=1 on the same cycle -> that bit ignored. pat_len=0 loads MAX_LEN.
5. CNT_W=2, 5 matches of pattern 11 via stream 1×6 with overlap on -> match_count 1,2,3,3,3 and count_sat=1 after the 4th match. clr_count -> 0/0. clr_count coincident with a match -> count 0 and seq_seen pulses.
6. Assert reset low asynchronously (between edges) after bits 1,0,1 -> outputs zero immediately. Release, then send bit 1 -> no pulse. Send 1,0,1,1 -> pulse.

Source files
------------

// File: rtl/seq_detect_prog.sv
// Run-time programmable serial bit-pattern detector with overlap control,
// input qualifier and saturating match counter.
module seq_detect_prog #(
  parameter int                 MAX_LEN         = 8,
  parameter int                 LEN_W           = 4,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(8'b0000_1011),
  parameter int                 DEFAULT_LEN     = 4,
  parameter int                 CNT_W           = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inp_bit,
  input  logic               inp_valid,
  input  logic               overlap_en,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               clr_count,
  output logic               seq_seen,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_seen;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sat;

  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W:0]     w_fill_inc;
  logic [LEN_W-1:0]   w_fill_next;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_len_clamped;
  logic               w_match;

  always_comb begin
    w_hist_next = {r_hist[MAX_LEN-2:0], inp_bit};
    w_fill_inc  = {1'b0, r_fill} + (LEN_W+1)'(1);
    w_fill_next = (w_fill_inc > (LEN_W+1)'(MAX_LEN)) ? LEN_W'(MAX_LEN)
                                                     : w_fill_inc[LEN_W-1:0];
    // Shifting by MAX_LEN yields zero, so a full-length pattern gets an all-ones mask.
    w_mask      = ~({MAX_LEN{1'b1}} << r_len);
    w_match     = inp_valid && !cfg_load &&
                  (((w_hist_next ^ r_pat) & w_mask) == '0) &&
                  (w_fill_next >= r_len);
    w_len_clamped = ((pat_len == '0) || (pat_len > LEN_W'(MAX_LEN))) ? LEN_W'(MAX_LEN)
                                                                     : pat_len;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pat  <= DEFAULT_PATTERN;
      r_len  <= LEN_W'(DEFAULT_LEN);
      r_hist <= '0;
      r_fill <= '0;
      r_seen <= 1'b0;
    end else begin
      r_seen <= 1'b0;
      if (cfg_load) begin
        r_pat  <= pattern;
        r_len  <= w_len_clamped;
        r_hist <= '0;
        r_fill <= '0;
      end else if (inp_valid) begin
        r_hist <= w_hist_next;
        // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
        r_fill <= (w_match && !overlap_en) ? '0 : w_fill_next;
        r_seen <= w_match;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (clr_count) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_match) begin
      if (&r_cnt) r_sat <= 1'b1;
      else        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign seq_seen    = r_seen;
  assign match_count = r_cnt;
  assign count_sat   = r_sat;

endmodule
